// File: rtl/ushift_n_if.sv
// Bus bundle for the ushift_n universal shift register: control/data inputs
// and the register/handshake outputs.
interface ushift_n_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
);
    logic [2:0]       mode;
    logic [WIDTH-1:0] d_par;
    logic             sir;
    logic             sil;
    logic             start;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q;
    logic             so_r;
    logic             so_l;
    logic             busy;
    logic             done;

    modport master (
        output mode, d_par, sir, sil, start, count,
        input  q, so_r, so_l, busy, done
    );

    modport slave (
        input  mode, d_par, sir, sil, start, count,
        output q, so_r, so_l, busy, done
    );
endinterface

// File: rtl/ushift_n.sv
// Parameterised universal shift register with direct one-op-per-clock mode
// and an N-step burst mode signalled by busy/done.
module ushift_n #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic      clk,
    input  logic      rst,
    ushift_n_if.slave bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] par,
        input logic             in_r,
        input logic             in_l
    );
        logic [WIDTH-1:0] res;
        case (op)
            3'b000:  res = cur;
            3'b001:  res = par;
            3'b010:  res = {in_r, cur[WIDTH-1:1]};
            3'b011:  res = {cur[WIDTH-2:0], in_l};
            3'b100:  res = {cur[0], cur[WIDTH-1:1]};
            3'b101:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'b110:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            3'b111:  res = {WIDTH{1'b0}};
            default: res = cur;
        endcase
        return res;
    endfunction

    // Only the shift/rotate ops are meaningful as multi-step bursts
    function automatic logic is_burst_op(input logic [2:0] op);
        return (op >= 3'b010) && (op <= 3'b110);
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic [2:0]       op_r, op_s;
    logic [CW-1:0]    rem_r, rem_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [CW-1:0]    count_sat_s;

    assign count_sat_s = (bus.count > WIDTH_C) ? WIDTH_C : bus.count;

    assign bus.q    = q_r;
    assign bus.so_r = q_r[0];
    assign bus.so_l = q_r[WIDTH-1];
    assign bus.busy = busy_r;
    assign bus.done = done_r;

    // State, datapath and handshake registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            q_r     <= {WIDTH{1'b0}};
            op_r    <= 3'b000;
            rem_r   <= ZERO_C;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            q_r     <= q_s;
            op_r    <= op_s;
            rem_r   <= rem_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state, datapath and handshake decode
    always_comb begin
        state_s = state_r;
        q_s     = q_r;
        op_s    = op_r;
        rem_s   = rem_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start && is_burst_op(bus.mode)) begin
                    // q holds on the accept edge; shifting starts next edge
                    op_s  = bus.mode;
                    rem_s = count_sat_s;
                    if (count_sat_s == ZERO_C) begin
                        done_s = 1'b1;
                        busy_s = 1'b0;
                    end else begin
                        state_s = RUN;
                        busy_s  = 1'b1;
                    end
                end else begin
                    q_s    = apply_op(bus.mode, q_r, bus.d_par, bus.sir, bus.sil);
                    busy_s = 1'b0;
                end
            end
            RUN: begin
                // Serial inputs are sampled live; mode/start/count are ignored
                q_s   = apply_op(op_r, q_r, bus.d_par, bus.sir, bus.sil);
                rem_s = rem_r - ONE_C;
                if (rem_r == ONE_C) begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = RUN;
                    busy_s  = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                rem_s   = ZERO_C;
            end
        endcase
    end
endmodule

// File: tb/tb_ushift_n.sv
// Self-checking bench for ushift_n: directed scenarios plus randomized
// direct ops and bursts checked against an arithmetic reference model.
module tb_ushift_n;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [7:0] exp_q;

    ushift_n_if #(.WIDTH(W)) bus ();
    ushift_n #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour written with plain integer arithmetic
    function automatic logic [7:0] ref_op(input logic [2:0] m, input logic [7:0] q,
                                          input logic [7:0] d, input logic si_r, input logic si_l);
        int v;
        v = int'(q);
        case (m)
            3'd0: v = v;
            3'd1: v = int'(d);
            3'd2: v = (v / 2) + (si_r ? 128 : 0);
            3'd3: v = ((v * 2) % 256) + (si_l ? 1 : 0);
            3'd4: v = (v / 2) + ((v % 2) * 128);
            3'd5: v = ((v * 2) % 256) + (v / 128);
            3'd6: v = (v / 2) + ((v >= 128) ? 128 : 0);
            default: v = 0;
        endcase
        return v[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mode  = 3'd0;
        bus.d_par = 8'h00;
        bus.sir   = 1'b0;
        bus.sil   = 1'b0;
        bus.start = 1'b0;
        bus.count = 4'd0;
    endtask

    task automatic do_direct(input logic [2:0] m, input logic [7:0] d, input logic st);
        bus.mode  = m;
        bus.d_par = d;
        bus.sir   = 1'($urandom_range(1));
        bus.sil   = 1'($urandom_range(1));
        bus.start = st;
        bus.count = 4'($urandom_range(15));
        exp_q = ref_op(m, exp_q, d, bus.sir, bus.sil);
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.q !== exp_q || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL direct mode=%0d: q=%h busy=%b done=%b, want q=%h busy=0 done=0",
                     m, bus.q, bus.busy, bus.done, exp_q);
        end
    endtask

    // Issue one burst and check every cycle of it against the model
    task automatic run_burst(input logic [2:0] op, input int cnt, input bit noise,
                             input bit rand_si, input logic si_val);
        int n;
        n = (cnt > W) ? W : cnt;
        bus.mode  = op;
        bus.count = 4'(cnt);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.q !== exp_q || bus.busy !== (n != 0) || bus.done !== (n == 0)) begin
            errors++;
            $display("FAIL burst_accept op=%0d n=%0d: q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     op, n, bus.q, bus.busy, bus.done, exp_q, (n != 0), (n == 0));
        end
        for (int i = 1; i <= n; i++) begin
            bus.sir = rand_si ? 1'($urandom_range(1)) : si_val;
            bus.sil = rand_si ? 1'($urandom_range(1)) : si_val;
            if (noise) begin
                bus.mode  = 3'($urandom_range(7));
                bus.d_par = 8'($urandom);
                bus.start = 1'($urandom_range(1));
                bus.count = 4'($urandom_range(15));
            end
            exp_q = ref_op(op, exp_q, 8'h00, bus.sir, bus.sil);
            step();
            checks++;
            if (bus.q !== exp_q || bus.busy !== (i < n) || bus.done !== (i == n)
                || bus.so_r !== exp_q[0] || bus.so_l !== exp_q[7]) begin
                errors++;
                $display("FAIL burst_step op=%0d %0d/%0d: q=%h busy=%b done=%b so_r=%b so_l=%b, want q=%h busy=%b done=%b",
                         op, i, n, bus.q, bus.busy, bus.done, bus.so_r, bus.so_l,
                         exp_q, (i < n), (i == n));
            end
        end
        idle_inputs();
        step();
        checks++;
        if (bus.q !== exp_q || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL burst_end op=%0d: q=%h busy=%b done=%b, want q=%h busy=0 done=0",
                     op, bus.q, bus.busy, bus.done, exp_q);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.q !== 8'h00 || bus.so_r !== 1'b0 || bus.so_l !== 1'b0
            || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: q=%h so_r=%b so_l=%b busy=%b done=%b, want all 0",
                     bus.q, bus.so_r, bus.so_l, bus.busy, bus.done);
        end
        exp_q = 8'h00;
        do_direct(3'd1, 8'h5A, 1'b0);
        #3 rst = 1'b0;
        #1;
        exp_q = 8'h00;
        checks++;
        if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: q=%h busy=%b done=%b, want 00/0/0",
                     bus.q, bus.busy, bus.done);
        end
        rst = 1'b1;
        do_direct(3'd1, 8'hA5, 1'b0);
        do_direct(3'd4, 8'h00, 1'b0);
        checks++;
        if (bus.q !== 8'hD2) begin
            errors++;
            $display("FAIL rotate_right_const: q=%h want d2", bus.q);
        end
    endtask

    task automatic test_burst_shl();
        do_direct(3'd1, 8'h96, 1'b0);
        run_burst(3'd3, 3, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.q !== 8'hB7) begin
            errors++;
            $display("FAIL shl_burst_const: q=%h want b7", bus.q);
        end
    endtask

    task automatic test_arith_sat();
        do_direct(3'd1, 8'h90, 1'b0);
        run_burst(3'd6, 2, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.q !== 8'hE4) begin
            errors++;
            $display("FAIL asr_const: q=%h want e4", bus.q);
        end
        do_direct(3'd1, 8'hFF, 1'b0);
        run_burst(3'd2, 15, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.q !== 8'h00) begin
            errors++;
            $display("FAIL srl_saturate_const: q=%h want 00", bus.q);
        end
    endtask

    task automatic test_rotate_count0();
        do_direct(3'd1, 8'h81, 1'b0);
        run_burst(3'd5, 8, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.q !== 8'h81) begin
            errors++;
            $display("FAIL rotate_full_const: q=%h want 81", bus.q);
        end
        do_direct(3'd1, 8'h6C, 1'b0);
        run_burst(3'd4, 0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.q !== 8'h6C) begin
            errors++;
            $display("FAIL count0_const: q=%h want 6c", bus.q);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_direct(3'd1, 8'hC3, 1'b0);
        bus.mode  = 3'd2;
        bus.count = 4'd6;
        bus.start = 1'b1;
        step();
        idle_inputs();
        step();
        step();
        #3 rst = 1'b0;
        #1;
        exp_q = 8'h00;
        checks++;
        if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst: q=%h busy=%b done=%b, want 00/0/0",
                     bus.q, bus.busy, bus.done);
        end
        step();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 8'h00) begin
                errors++;
                $display("FAIL aborted_burst_quiet cyc%0d: q=%h busy=%b done=%b, want 00/0/0",
                         i, bus.q, bus.busy, bus.done);
            end
        end
        do_direct(3'd1, 8'h3C, 1'b0);
        checks++;
        if (bus.q !== 8'h3C) begin
            errors++;
            $display("FAIL load_after_reset: q=%h want 3c", bus.q);
        end
    endtask

    task automatic test_start_handling();
        do_direct(3'd1, 8'h47, 1'b1);
        do_direct(3'd0, 8'h00, 1'b1);
        do_direct(3'd7, 8'hFF, 1'b1);
        do_direct(3'd1, 8'hE1, 1'b0);
        run_burst(3'd4, 4, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_direct(3'd1, 8'h2B, 1'b0);
        // Second start presented in the done cycle of the first burst
        bus.mode  = 3'd3;
        bus.count = 4'd2;
        bus.start = 1'b1;
        bus.sil   = 1'b1;
        step();
        step();
        exp_q = ref_op(3'd3, exp_q, 8'h00, 1'b1, 1'b1);
        step();
        exp_q = ref_op(3'd3, exp_q, 8'h00, 1'b1, 1'b1);
        bus.mode = 3'd5;
        bus.count = 4'd1;
        checks++;
        if (bus.done !== 1'b1 || bus.q !== exp_q) begin
            errors++;
            $display("FAIL b2b_first_done: done=%b q=%h, want 1 %h", bus.done, bus.q, exp_q);
        end
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.q !== exp_q) begin
            errors++;
            $display("FAIL b2b_second_accept: busy=%b q=%h, want 1 %h", bus.busy, bus.q, exp_q);
        end
        exp_q = ref_op(3'd5, exp_q, 8'h00, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== exp_q) begin
            errors++;
            $display("FAIL b2b_second_done: done=%b busy=%b q=%h, want 1 0 %h",
                     bus.done, bus.busy, bus.q, exp_q);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        logic [2:0] m;
        for (int i = 0; i < 30; i++) begin
            m = 3'($urandom_range(7));
            if (m >= 3'd2 && m <= 3'd6 && $urandom_range(1) == 1) begin
                run_burst(m, int'($urandom_range(15)), 1'b1, 1'b1, 1'b0);
            end else begin
                do_direct(m, 8'($urandom), (m < 3'd2 || m == 3'd7) ? 1'($urandom_range(1)) : 1'b0);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_q  = 8'h00;
        rst    = 1'b0;
        idle_inputs();
        repeat (3) step();
        #3 rst = 1'b1;
        step();
        test_reset();
        test_burst_shl();
        test_arith_sat();
        test_rotate_count0();
        test_reset_mid_burst();
        test_start_handling();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ushift_n.md
# ushift_n

Parameterised universal shift register. It holds a WIDTH-bit word and supports hold, parallel load, synchronous clear, logical shifts, rotates and arithmetic shift right. Operations run one per clock in direct mode, or as an N-step burst with a busy/done handshake. It sits in the datapath where a fixed 4-bit universal shifter is too narrow and where multi-position shifts must run without external sequencing.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CW, $clog2(WIDTH)+1, width of the count input (must hold the value WIDTH)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- mode  in  3  operation select (encoding below)
- d_par  in  WIDTH  parallel load data
- sir  in  1  serial input entering MSB on shift right
- sil  in  1  serial input entering LSB on shift left
- start  in  1  begin a burst of count steps of the current mode
- count  in  CW  number of burst steps; values >WIDTH saturate to WIDTH
- q  out  WIDTH  register contents
- so_r  out  1  q[0] (serial out, right side)
- so_l  out  1  q[WIDTH-1] (serial out, left side)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when a burst completes

## Operation
- mode encoding:
  - 000: hold
  - 001: load d_par
  - 010: logical shift right, sir→MSB
  - 011: logical shift left, sil→LSB
  - 100: rotate right
  - 101: rotate left
  - 110: arithmetic shift right, MSB replicated
  - 111: synchronous clear
- FSM states IDLE and RUN; reset enters IDLE.
- IDLE, start=0: mode is applied to q every clock edge (direct mode).
- IDLE, start=1, mode in 010–110:
  - Latch mode into op_r and min(count,WIDTH) into rem.
  - q holds on this edge.
  - If the latched count is 0: stay IDLE, busy stays 0, done=1 for one cycle.
  - Otherwise go to RUN, busy=1.
- IDLE, start=1, mode in 000/001/111: start is ignored and mode applies normally.
- RUN, each edge:
  - Apply op_r to q and decrement rem.
  - sir/sil are sampled live each cycle, not latched.
  - On the edge where rem goes 1→0: return to IDLE, busy=0, done=1.
- RUN ignores mode, d_par, start and count. A start while busy is dropped, not queued.
- so_r/so_l are combinational from q.
- Reset at any time, including mid-burst: q=0, busy=0, done=0, state IDLE, rem=0. An aborted burst never produces done.

## Timing
- Reset values: q=0, so_r=0, so_l=0, busy=0, done=0.
- Direct mode latency: q reflects the op one edge after mode is presented.
- Burst with start sampled at edge k and count N≥1:
  - busy is high from after edge k until after edge k+N.
  - Shifts occur on edges k+1..k+N.
  - done is high during the cycle after edge k+N.
  - Direct mode resumes from edge k+N+1.
- Back-to-back bursts: start may be asserted in the done cycle and is accepted at edge k+N+1.
- Burst with count=0: done is high for the cycle after edge k; q unchanged.
- Width rules:
  - Shifts move exactly one bit per step.
  - A burst of WIDTH logical shifts fully replaces q with serial-in bits.
  - A burst of WIDTH rotates restores q.

## Test plan
- Reset/load: pulse rst low mid-cycle → q=8'h00, busy=0, done=0 asynchronously. Then mode=001, d_par=8'hA5 → q=8'hA5 next edge. Then mode=100 for one edge → q=8'hD2.
- Burst shift left: q=8'h96, start with mode=011, count=3, sil=1 → q=8'h2D, 8'h5B, 8'hB7 on edges k+1..k+3. busy is high for 3 cycles, done pulses once, and mode changes during the burst have no effect.
- Arithmetic/saturation:
  - q=8'h90, mode=110, count=2 → q=8'hE4.
  - q=8'hFF, mode=010, sir=0, count=15 → saturates to 8 steps, q=8'h00, done after edge k+8.
- Rotate/count 0:
  - q=8'h81, mode=101, count=8 → q=8'h81 after 8 steps, so_l/so_r track every step.
  - count=0 → q unchanged, busy never high, done for 1 cycle.
- Reset mid-burst: start shift right, count=6; assert rst after step 2 → q=0, busy=0, no done. After rst release, a direct load of 8'h3C works.
- Start handling:
  - start with mode=001 → plain load, no busy, no done.
  - start asserted during RUN → ignored; burst length unchanged.
